// File: rtl/palette_sequencer.sv
// Palette sequencer: drives the 8-bit palette select for the palette lookup.
// It auto-steps every HOLD_FRAMES frame_ticks, in wrap or ping-pong order.
// It also accepts host palette switches over a valid/ready handshake.
// Every id change lands on a frame_tick, so a palette never changes mid-frame.
// Optional crossfade outputs (next_color_id, blend) are built only when
// the macro PALETTE_SEQ_FADE_EN is defined.
module palette_sequencer #(
    parameter int unsigned NUM_PALETTES = 3,
    parameter int unsigned HOLD_FRAMES  = 60,
    parameter int unsigned CNT_W        = $clog2(HOLD_FRAMES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       auto_en,
    input  logic       pingpong,
    input  logic       req_valid,
    input  logic [7:0] req_id,
    output logic       req_ready,
    output logic       req_err,
    output logic [7:0] color_id,
`ifdef PALETTE_SEQ_FADE_EN
    output logic [7:0] next_color_id,
    output logic [3:0] blend,
`endif
    output logic       id_changed
);

    localparam int unsigned ID_W = 8;
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_PALETTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            dir_down_q, dir_down_d;
    logic            pend_q, pend_d;
    logic [ID_W-1:0] pend_id_q, pend_id_d;
    logic [ID_W-1:0] color_q, color_d;
    logic            changed_q, changed_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;

    logic [ID_W-1:0] adv_id;
    logic            adv_down;
    logic            accept;
    logic            in_range;

    // Id and direction the next auto-advance would produce
    always_comb begin
        adv_id   = color_q;
        adv_down = dir_down_q;
        if (NUM_PALETTES == 1) begin
            adv_id = '0;
        end else if (!pingpong) begin
            adv_id = (color_q >= LAST_ID) ? '0 : color_q + ID_W'(1);
        end else if (!dir_down_q) begin
            if (color_q >= LAST_ID) begin
                adv_down = 1'b1;
                adv_id   = LAST_ID - ID_W'(1);
            end else begin
                adv_id = color_q + ID_W'(1);
            end
        end else begin
            if (color_q == '0) begin
                adv_down = 1'b0;
                adv_id   = ID_W'(1);
            end else begin
                adv_id = color_q - ID_W'(1);
            end
        end
    end

    // Next-state, counter, handshake and output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        pend_d     = pend_q;
        pend_id_d  = pend_id_q;
        color_d    = color_q;
        err_d      = 1'b0;
        accept     = req_valid & ready_q;
        in_range   = {1'b0, req_id} < 9'(NUM_PALETTES);

        unique case (state_q)
            S_IDLE:  if (auto_en)  state_d = S_RUN;
            S_RUN:   if (!auto_en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A pending request beats an auto-advance due on the same tick
        if (frame_tick && pend_q) begin
            color_d = pend_id_q;
            pend_d  = 1'b0;
            cnt_d   = '0;
        end else if (frame_tick && (state_q == S_RUN) && (state_d == S_RUN)) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d      = '0;
                color_d    = adv_id;
                dir_down_d = adv_down;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Accepted requests are applied no earlier than the following tick
        if (accept) begin
            if (in_range) begin
                pend_d    = 1'b1;
                pend_id_d = req_id;
            end else begin
                err_d = 1'b1;
            end
        end

        ready_d   = ~pend_d;
        changed_d = (color_d != color_q);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_id_q  <= '0;
            color_q    <= '0;
            changed_q  <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_down_q <= dir_down_d;
            pend_q     <= pend_d;
            pend_id_q  <= pend_id_d;
            color_q    <= color_d;
            changed_q  <= changed_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    assign color_id   = color_q;
    assign id_changed = changed_q;
    assign req_err    = err_q;
    assign req_ready  = ready_q;

`ifdef PALETTE_SEQ_FADE_EN
    localparam logic [CNT_W-1:0] FADE_START =
        (HOLD_FRAMES > 16) ? CNT_W'(HOLD_FRAMES - 16) : '0;

    logic [3:0] blend_q, blend_d;
    logic       live_q;

    // Crossfade ramp over the last 16 frames of a hold period
    always_comb begin
        blend_d = blend_q;
        if ((state_d != S_RUN) || (color_d != color_q)) begin
            blend_d = '0;
        end else if (frame_tick && (state_q == S_RUN) &&
                     (cnt_q >= FADE_START) && (blend_q != 4'hF)) begin
            blend_d = blend_q + 4'd1;
        end
    end

    // Fade registers; live_q holds next_color_id at zero while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blend_q <= '0;
            live_q  <= 1'b0;
        end else begin
            blend_q <= blend_d;
            live_q  <= 1'b1;
        end
    end

    assign blend         = blend_q;
    assign next_color_id = live_q ? adv_id : '0;
`endif

endmodule

// File: tb/tb_palette_sequencer.sv
// Scoreboard bench for palette_sequencer (NUM_PALETTES=3, HOLD_FRAMES=4).
// Stimulus pushes expected ids / error tokens; a negedge monitor pops them
// whenever the DUT pulses id_changed or req_err.
module tb_palette_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       auto_en;
    logic       pingpong;
    logic       req_valid;
    logic [7:0] req_id;
    logic       req_ready;
    logic       req_err;
    logic [7:0] color_id;
    logic       id_changed;
`ifdef PALETTE_SEQ_FADE_EN
    logic [7:0] next_color_id;
    logic [3:0] blend;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic       err_q[$];

    palette_sequencer #(.NUM_PALETTES(3), .HOLD_FRAMES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .auto_en    (auto_en),
        .pingpong   (pingpong),
        .req_valid  (req_valid),
        .req_id     (req_id),
        .req_ready  (req_ready),
        .req_err    (req_err),
        .color_id   (color_id),
`ifdef PALETTE_SEQ_FADE_EN
        .next_color_id (next_color_id),
        .blend         (blend),
`endif
        .id_changed (id_changed)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: every id_changed / req_err pulse must match a queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (id_changed) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_id_changed: got color_id %0d expected no change", color_id);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (color_id != e) begin
                        errors++;
                        $display("FAIL id_change_value: got %0d expected %0d", color_id, e);
                    end
                end
            end
            if (req_err) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req_err: got 1 expected 0");
                end else begin
                    void'(err_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One-cycle frame_tick, then two idle cycles so the monitor has run
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        idle(2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Single-cycle request; returns at the negedge after the accepting edge
    task automatic request(input logic [7:0] id, input logic with_tick);
        @(negedge clk);
        req_valid  = 1'b1;
        req_id     = id;
        frame_tick = with_tick;
        @(negedge clk);
        req_valid  = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; auto_en = 1'b0; pingpong = 1'b0;
        req_valid = 1'b0; req_id = '0;
        idle(2);
        check("reset_color_id", color_id, 0);
        check("reset_id_changed", id_changed, 0);
        check("reset_req_err", req_err, 0);
        check("reset_req_ready", req_ready, 1);
`ifdef PALETTE_SEQ_FADE_EN
        check("reset_blend", blend, 0);
`endif
        rst_n = 1'b1;
        idle(2);

        // Wrap order: 0->1->2->0 every 4 ticks
        auto_en = 1'b1; pingpong = 1'b0;
        idle(2);
        exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd0);
        ticks(3);
        check("wrap_hold_before_tick4", color_id, 0);
        ticks(9);
        check("wrap_all_advances_seen", exp_q.size(), 0);
        check("wrap_final_id", color_id, 0);
        auto_en = 1'b0;
        idle(2);

        // Ping-pong order: 1,2,1,0
        auto_en = 1'b1; pingpong = 1'b1;
        idle(2);
        exp_q.push_back(8'd1); exp_q.push_back(8'd2);
        exp_q.push_back(8'd1); exp_q.push_back(8'd0);
        ticks(16);
        check("pingpong_all_advances_seen", exp_q.size(), 0);
        check("pingpong_final_id", color_id, 0);
        auto_en = 1'b0;
        idle(2);

        // Manual request applied only at the next tick
        exp_q.push_back(8'd2);
        request(8'd2, 1'b0);
        check("manual_ready_low", req_ready, 0);
        check("manual_color_held", color_id, 0);
        idle(3);
        check("manual_color_held_later", color_id, 0);
        tick();
        check("manual_applied", color_id, 2);
        check("manual_pulse_seen", exp_q.size(), 0);
        check("manual_ready_back", req_ready, 1);
        check("manual_pulse_one_cycle", id_changed, 0);

        // Out-of-range request
        err_q.push_back(1'b1);
        request(8'd5, 1'b0);
        check("bad_ready_stays", req_ready, 1);
        idle(1);
        check("bad_err_seen", err_q.size(), 0);
        check("bad_err_one_cycle", req_err, 0);
        ticks(3);
        check("bad_color_unchanged", color_id, 2);

        // Request equal to current id: consumed without a pulse
        request(8'd2, 1'b0);
        check("same_ready_low", req_ready, 0);
        tick();
        check("same_color", color_id, 2);
        check("same_ready_back", req_ready, 1);

        // Handshake in the same cycle as a tick: applied on the next tick
        request(8'd1, 1'b1);
        idle(1);
        check("same_cycle_not_applied", color_id, 2);
        check("same_cycle_pending", req_ready, 0);
        exp_q.push_back(8'd1);
        tick();
        check("same_cycle_applied", color_id, 1);

        // Collision: pending 0 beats advance 1->2, counter restarts
        pingpong = 1'b0; auto_en = 1'b1;
        idle(2);
        ticks(3);
        request(8'd0, 1'b0);
        exp_q.push_back(8'd0);
        tick();
        check("collision_pending_wins", color_id, 0);
        ticks(3);
        check("collision_counter_restart", color_id, 0);
        exp_q.push_back(8'd1);
        tick();
        check("collision_next_advance", color_id, 1);

        // Reset mid-run with id 2 and a pending request
        exp_q.push_back(8'd2);
        ticks(4);
        check("pre_reset_id", color_id, 2);
        request(8'd1, 1'b0);
        check("pre_reset_pending", req_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midreset_color_id", color_id, 0);
        check("midreset_req_ready", req_ready, 1);
        check("midreset_id_changed", id_changed, 0);
`ifdef PALETTE_SEQ_FADE_EN
        check("midreset_blend", blend, 0);
`endif
        auto_en = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        tick();
        check("post_reset_pending_lost", color_id, 0);
        check("queues_drained", exp_q.size() + err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
